// File: rtl/mips_defs.sv
// mips_defs: constants shared by the EX-stage control path.
//   ALUOP_RTYPE    : main-control ALUOp value that hands decode to funct
//   F_*            : R-type funct codes handled by the multiply/divide unit
//   md_state_t     : muldiv_sequencer FSM state encoding
//   is_muldiv_funct: true for any funct the multiply/divide unit owns
package mips_defs;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_mfhi  = 6'd16;
  localparam logic [5:0] F_mflo  = 6'd18;
  localparam logic [5:0] F_multu = 6'd25;
  localparam logic [5:0] F_divu  = 6'd27;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIN  = 2'd3
  } md_state_t;

  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f == F_multu) || (f == F_divu) || (f == F_mfhi) || (f == F_mflo);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage <-> multiply/divide unit connection.
//   master (pipeline): drives ex_valid, ALUOp, funct, src_a, src_b
//   slave  (unit)    : drives busy, done, stall, hilo_rdata, hi, lo, state
//
// Handshake: an instruction is offered whenever ex_valid is high with
// ALUOp == R-type. The unit "accepts" a MULTU/DIVU only on a clock edge in
// which it is idle (stall low); while stall is high the pipeline must hold
// and re-present the same instruction, which is evaluated again the first
// cycle the unit is idle. Any other instruction is never stalled.
// state is a debug view of the sequencer FSM.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  import mips_defs::*;

  logic             ex_valid;
  logic [1:0]       ALUOp;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;

  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hilo_rdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  md_state_t        state;

  modport master (
    output ex_valid, ALUOp, funct, src_a, src_b,
    input  busy, done, stall, hilo_rdata, hi, lo, state
  );

  modport slave (
    input  ex_valid, ALUOp, funct, src_a, src_b,
    output busy, done, stall, hilo_rdata, hi, lo, state
  );

endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift registers and shared (WIDTH+1)-bit adder/subtractor
// for the iterative multiply/divide unit.
//   clk, rst        : clock, synchronous active-high reset
//   load            : capture operands (mode_div selects operand placement)
//   step            : perform one iteration
//   mode_div        : 1 = restoring divide step, 0 = shift-add multiply step
//   op_a, op_b      : operands (multiplicand/dividend, multiplier/divisor)
//   hi_nxt, lo_nxt  : register contents after the current step; the
//                     sequencer latches these into HI/LO on the final step
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  // acc: product high half / partial remainder
  // sh : multiplier shifting out (low product bits shifting in) /
  //      dividend shifting out (quotient bits shifting in)
  // opnd: multiplicand / divisor
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;

  logic [WIDTH:0]   x;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sel;
  logic             borrow;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sh_nxt;

  always_comb begin
    x       = mode_div ? {acc, sh[WIDTH-1]} : {1'b0, acc};
    sum     = mode_div ? (x - {1'b0, opnd}) : (x + {1'b0, opnd});
    sel     = '0;
    borrow  = 1'b0;
    acc_nxt = acc;
    sh_nxt  = sh;
    if (mode_div) begin
      // Partial remainder is always < divisor, so a negative trial result
      // shows up as bit WIDTH set: restore by keeping the shifted value.
      borrow  = sum[WIDTH];
      acc_nxt = borrow ? x[WIDTH-1:0] : sum[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], ~borrow};
    end else begin
      // Add when the current multiplier bit is set; the carry (bit WIDTH)
      // becomes the new top bit after the right shift.
      sel     = sh[0] ? sum : x;
      acc_nxt = sel[WIDTH:1];
      sh_nxt  = {sel[0], sh[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc  <= '0;
      sh   <= '0;
      opnd <= '0;
    end else if (load) begin
      acc  <= '0;
      sh   <= mode_div ? op_a : op_b;
      opnd <= mode_div ? op_b : op_a;
    end else if (step) begin
      acc  <= acc_nxt;
      sh   <= sh_nxt;
    end
  end

  assign hi_nxt = acc_nxt;
  assign lo_nxt = sh_nxt;

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative unsigned MULTU/DIVU unit beside the EX-stage
// ALU; owns HI/LO and serves MFHI/MFLO.
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_sequencer_if.slave
//     in : ex_valid, ALUOp, funct, src_a, src_b
//     out: busy  (MUL/DIV/FIN), done (one-cycle pulse in FIN),
//          stall (busy and a muldiv funct is presented),
//          hilo_rdata (HI when funct is MFHI, else LO), hi, lo,
//          state (FSM debug view)
// CNT_W must satisfy 2**CNT_W == WIDTH.
module muldiv_sequencer
  import mips_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst,
  muldiv_sequencer_if.slave bus
);

  logic is_rtype;
  logic dec_mul;
  logic dec_div;
  logic dec_any;

  assign is_rtype = bus.ex_valid && (bus.ALUOp == ALUOP_RTYPE);
  assign dec_mul  = is_rtype && (bus.funct == F_multu);
  assign dec_div  = is_rtype && (bus.funct == F_divu);
  assign dec_any  = is_rtype && is_muldiv_funct(bus.funct);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic             dp_load;
  logic             dp_step;
  logic             dp_div;
  logic [WIDTH-1:0] dp_hi_nxt;
  logic [WIDTH-1:0] dp_lo_nxt;
  logic             last_iter;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign dp_load   = (state == MD_IDLE) && (dec_mul || (dec_div && (bus.src_b != '0)));
  assign dp_step   = (state == MD_MUL) || (state == MD_DIV);
  // In IDLE the mode only steers operand placement at load time.
  assign dp_div    = (state == MD_IDLE) ? dec_div : (state == MD_DIV);

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .step     (dp_step),
    .mode_div (dp_div),
    .op_a     (bus.src_a),
    .op_b     (bus.src_b),
    .hi_nxt   (dp_hi_nxt),
    .lo_nxt   (dp_lo_nxt)
  );

  // HI/LO are written only on the edge entering FIN, so they hold steady
  // through MUL/DIV and the result is visible in the same cycle as done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (dec_mul) begin
            state  <= MD_MUL;
            cnt    <= '0;
            busy_q <= 1'b1;
          end else if (dec_div) begin
            busy_q <= 1'b1;
            if (bus.src_b != '0) begin
              state <= MD_DIV;
              cnt   <= '0;
            end else begin
              // Divide by zero finishes immediately with a fixed result.
              state  <= MD_FIN;
              hi_q   <= bus.src_a;
              lo_q   <= '1;
              done_q <= 1'b1;
            end
          end
        end
        MD_MUL, MD_DIV: begin
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            state  <= MD_FIN;
            hi_q   <= dp_hi_nxt;
            lo_q   <= dp_lo_nxt;
            done_q <= 1'b1;
          end
        end
        MD_FIN: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= MD_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.stall      = busy_q && dec_any;
  assign bus.hilo_rdata = (bus.funct == F_mfhi) ? hi_q : lo_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of muldiv_sequencer
// against a plain-arithmetic reference (64-bit product, / and %).
module tb_muldiv_sequencer;
  import mips_defs::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_hilo;
  logic [5:0]  cur_funct;
  logic        cur_rtype;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] ref_result(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    if (!is_div) return 64'(a) * 64'(b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  function automatic logic exp_stall_now();
    return cur_rtype && (cur_funct == F_multu || cur_funct == F_divu ||
                         cur_funct == F_mfhi  || cur_funct == F_mflo);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ev, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    bus.ex_valid = ev;
    bus.ALUOp    = op;
    bus.funct    = f;
    bus.src_a    = a;
    bus.src_b    = b;
    cur_rtype    = ev && (op == 2'b10);
    cur_funct    = f;
  endtask

  // Called at a negedge right after an op was put on the bus with the unit
  // idle. Follows it cycle by cycle to done, then checks the first idle cycle.
  // At cycle 1 the inputs switch to f1; at cycle sw_cyc they switch to f2.
  task automatic wait_done(input int exp_lat, input logic [5:0] f1, input logic [5:0] f2,
                           input int sw_cyc, input logic [31:0] a2, input logic [31:0] b2);
    int          cyc;
    bit          seen;
    logic [63:0] exp;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      check_eq("stall_busy", 64'(bus.stall), 64'(exp_stall_now()));
      if (bus.done) begin
        seen = 1'b1;
        check_eq("latency", 64'(cyc), 64'(exp_lat));
        check_eq("busy_in_fin", 64'(bus.busy), 64'd1);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
        check_eq("hilo_result", {bus.hi, bus.lo}, exp);
        model_hilo = exp;
      end else begin
        check_eq("busy_running", 64'(bus.busy), 64'd1);
        check_eq("hilo_hold", {bus.hi, bus.lo}, model_hilo);
      end
      if (cyc == 1) drive(1'b1, 2'b10, f1, $urandom, $urandom);
      if (cyc == sw_cyc) drive(1'b1, 2'b10, f2, a2, b2);
    end
    if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    check_eq("idle_stall", 64'(bus.stall), 64'd0);
    check_eq("idle_done", 64'(bus.done), 64'd0);
    check_eq("idle_rdata", 64'(bus.hilo_rdata),
             64'((cur_funct == F_mfhi) ? model_hilo[63:32] : model_hilo[31:0]));
  endtask

  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] f1);
    exp_q.push_back(ref_result(is_div, a, b));
    drive(1'b1, 2'b10, is_div ? F_divu : F_multu, a, b);
    wait_done((is_div && b == 32'd0) ? 1 : 33, f1, 6'd0, 0, 32'd0, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [5:0] follow_f[5];
  int         n_done;

  initial begin
    follow_f = '{F_mflo, F_mfhi, 6'd32, 6'd34, 6'd0};
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    model_hilo = 64'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check_eq("rst_state", 64'(bus.state), 64'(MD_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, F_mfhi);
    run_op(1'b1, 32'd100, 32'd7, 6'd32);
    run_op(1'b1, 32'd5, 32'd0, F_mflo);
    run_op(1'b0, 32'd3, 32'd4, F_mflo);

    // Non-muldiv and a second MULTU while busy; the MULTU is taken after done.
    exp_q.push_back(ref_result(1'b0, 32'h1234_5678, 32'h9ABC_DEF0));
    exp_q.push_back(ref_result(1'b0, 32'hCAFE_0001, 32'h0000_0003));
    drive(1'b1, 2'b10, F_multu, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_done(33, 6'd32, F_multu, 3, 32'hCAFE_0001, 32'h0000_0003);
    wait_done(33, 6'd32, 6'd0, 0, 32'd0, 32'd0);

    // Non-R-type and invalid slots never start an operation.
    drive(1'b1, 2'b00, F_multu, 32'd7, 32'd9);
    @(negedge clk);
    check_eq("aluop00_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    check_eq("aluop00_busy", 64'(bus.busy), 64'd0);
    drive(1'b0, 2'b10, F_divu, 32'd7, 32'd9);
    @(negedge clk);
    @(negedge clk);
    check_eq("novalid_busy", 64'(bus.busy), 64'd0);
    check_eq("novalid_hilo", {bus.hi, bus.lo}, model_hilo);

    // Randomized operations
    for (int i = 0; i < 14; i++) begin
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      d = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(d, a, b, follow_f[$urandom_range(0, 4)]);
    end

    // Reset during a divide abandons it with no done pulse.
    drive(1'b1, 2'b10, F_divu, 32'hDEAD_BEEF, 32'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) drive(1'b1, 2'b10, 6'd32, $urandom, $urandom);
    end
    check_eq("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_hilo = 64'd0;
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_done", 64'(bus.done), 64'd0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_eq("midrst_no_done", 64'(n_done), 64'd0);
    check_eq("midrst_idle", 64'(bus.busy), 64'd0);

    // One more operation after the abandoned one still works.
    run_op(1'b1, 32'd1000, 32'd33, F_mfhi);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative unsigned multiply/divide unit in the EX stage, beside the main ALU. Owns the HI/LO registers.
- Decodes R-type funct codes MULTU, DIVU, MFHI and MFLO.
- Computes one result bit per cycle and drives a stall to the hazard unit while busy.
- Pipeline-facing interface matches the ALU control path: ALUOp = 2'b10 plus funct selects the operation.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a valid instruction this cycle.
- ALUOp  in  2  from main control; only 2'b10 (R-type) is decoded.
- funct  in  6  instruction funct field.
- src_a  in  WIDTH  rs operand (multiplicand / dividend).
- src_b  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated.
- stall  out  1  hold the IF/ID/EX stages this cycle.
- hilo_rdata  out  WIDTH  HI if funct == MFHI, otherwise LO (combinational).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Decode is active only when ex_valid & ALUOp == 2'b10:
  - funct 6'd25 = MULTU
  - funct 6'd27 = DIVU
  - funct 6'd16 = MFHI
  - funct 6'd18 = MFLO
  - any other funct is ignored.
- Reset (synchronous, highest priority): state = IDLE; hi, lo, counter and internal accumulators = 0; busy = 0; done = 0. Reset mid-operation abandons the operation and no done pulse is produced.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - MULTU: capture operands, counter = 0, go to MUL.
  - DIVU with src_b != 0: capture operands, go to DIV.
  - DIVU with src_b == 0: go to FIN with result hi = src_a, lo = 32'hFFFF_FFFF.
- MUL: shift-add, one multiplier bit per cycle using a (WIDTH+1)-bit add so the carry is kept. After WIDTH cycles (counter == WIDTH-1) go to FIN. Result {hi, lo} = src_a * src_b as a full 64-bit unsigned product.
- DIV: restoring division, one quotient bit per cycle. After WIDTH cycles go to FIN. Result lo = quotient, hi = remainder.
- FIN: hi/lo are written on the clock edge entering FIN and are visible in FIN. done = 1 for exactly this one cycle. Next state is IDLE.
- busy = 1 in MUL, DIV and FIN; 0 in IDLE.
- Latency from the accept edge to HI/LO visible: MULTU and DIVU = WIDTH + 1 cycles (33); DIVU by zero = 1 cycle.
- hi/lo hold their values until the next FIN or reset. They never change during MUL/DIV; accumulation uses internal registers only.
- stall = busy & ex_valid & ALUOp == 2'b10 & funct in {MULTU, DIVU, MFHI, MFLO}. Combinational; deasserts in IDLE.
  - A held instruction is re-presented by the pipeline and evaluated again once the unit is IDLE.
  - An MFHI/MFLO stalled behind FIN reads the new value in the following cycle.
- Issue while busy: the new MULTU/DIVU is not accepted; it stalls instead. Only IDLE accepts.
- Simultaneous FIN and a new MULTU/DIVU: the new operation stalls and is accepted on the next IDLE cycle, so back-to-back operations are 1 cycle apart.
- Non-muldiv instructions never stall and do not affect state, even while busy.
- Operands are captured at accept; later src_a/src_b changes have no effect.

Decomposition:
- Shared package (mips_defs), next to the existing ALU control constants:
  - funct constants F_multu, F_divu, F_mfhi, F_mflo
  - ALUOp encoding constant for R-type
  - FSM state encodings for muldiv_sequencer
- One natural sub-module: muldiv_datapath. It holds the accumulator/shift registers and the (WIDTH+1)-bit adder/subtractor, controlled by the FSM's step, mode (mul/div) and load strobes. The FSM, counter, HI/LO and stall logic stay in muldiv_sequencer.

Test Plan:
- MULTU with src_a = 32'hFFFF_FFFF, src_b = 32'hFFFF_FFFF -> done after 33 cycles; hi = 32'hFFFF_FFFE, lo = 32'h0000_0001; busy high for 33 cycles.
- DIVU with src_a = 100, src_b = 7 -> lo = 14, hi = 2 at done. Then DIVU with src_b = 0, src_a = 5 -> done the next cycle; hi = 5, lo = 32'hFFFF_FFFF.
- MULTU 3*4, then MFLO presented every cycle while busy -> stall = 1 for every busy cycle, stall = 0 in the first IDLE cycle, hilo_rdata = 12.
- While busy, issue an add (funct 32) and a MULTU -> stall stays 0 for the add; the MULTU stalls and is accepted in the cycle after done.
- rst asserted at iteration 10 of a DIVU -> next cycle busy = 0, hi = lo = 0, and no done pulse.
- ALUOp = 2'b00 with funct = 25 and ex_valid = 1 -> no accept, busy stays 0, stall = 0.
